vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_timing_gen_if.sv | 29 ++
 rtl/vga_axis_counter.sv | 47 ++++
 rtl/vga_timing_gen.sv | 83 ++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing types and default 640x480@60 constants.
// Downstream muxes and sprite blocks import this for vstate_t.
package vga_pkg;

  typedef enum logic [1:0] {
    VActive,
    VFrontPorch,
    VSync,
    VBackPorch
  } vstate_t;

  localparam int H_VIS_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int V_VIS_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  function automatic vstate_t vdecode(
    input logic [9:0] v,
    input logic [9:0] vis,
    input logic [9:0] fp_end,
    input logic [9:0] sync_end
  );
    vstate_t s;
    if (v < vis)           s = VActive;
    else if (v < fp_end)   s = VFrontPorch;
    else if (v < sync_end) s = VSync;
    else                   s = VBackPorch;
    return s;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bundle of the timing generator's enable and video outputs.
// master drives timing, slave consumes it.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic       pixelEn;
  logic       HS;
  logic       VS;
  logic       blank_n;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       frameStart;
  vstate_t    VState;

  modport master (
    input  pixelEn,
    output HS, VS, blank_n,
    output DrawX, DrawY,
    output frameStart, VState
  );

  modport slave (
    output pixelEn,
    input  HS, VS, blank_n,
    input  DrawX, DrawY,
    input  frameStart, VState
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter with registered sync.
// vis decodes the next count so the parent can register blanking.
module vga_axis_counter #(
  parameter int TOTAL      = 800,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 751,
  parameter int VIS        = 640
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [9:0] count,
  output logic       wrap,
  output logic       sync_n,
  output logic       vis
);

  localparam logic [9:0] LAST = 10'(TOTAL - 1);
  localparam logic [9:0] SS   = 10'(SYNC_START);
  localparam logic [9:0] SE   = 10'(SYNC_END);
  localparam logic [9:0] VL   = 10'(VIS);

  logic [9:0] cnt_q, cnt_d;
  logic       sync_q, sync_d;

  always_comb begin
    cnt_d = cnt_q;
    wrap  = en && (cnt_q == LAST);
    if (en) cnt_d = wrap ? '0 : cnt_q + 10'd1;
    sync_d = !((cnt_d >= SS) && (cnt_d <= SE));
    vis    = cnt_d < VL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sync_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= sync_d;
    end
  end

  assign count  = cnt_q;
  assign sync_n = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: chained pixel/line counters, syncs,
// registered blanking and a one-cycle frame-start pulse.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VIS  = H_VIS_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_VIS  = V_VIS_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF
) (
  input  logic       frame_Clk,
  input  logic       Reset,
  input  logic       pixelEn,
  output logic       HS,
  output logic       VS,
  output logic       blank_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frameStart,
  output vstate_t    VState
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] VV  = 10'(V_VIS);
  localparam logic [9:0] VFE = 10'(V_VIS + V_FP);
  localparam logic [9:0] VSE = 10'(V_VIS + V_FP + V_SYNC);

  logic h_wrap, v_wrap;
  logic h_vis, v_vis;
  logic blank_q, fs_q;

  vga_axis_counter #(
    .TOTAL     (H_TOT),
    .SYNC_START(H_VIS + H_FP),
    .SYNC_END  (H_VIS + H_FP + H_SYNC - 1),
    .VIS       (H_VIS)
  ) u_h (
    .clk   (frame_Clk),
    .rst   (Reset),
    .en    (pixelEn),
    .count (DrawX),
    .wrap  (h_wrap),
    .sync_n(HS),
    .vis   (h_vis)
  );

  // Line counter steps only on the pixel counter's wrap edge.
  vga_axis_counter #(
    .TOTAL     (V_TOT),
    .SYNC_START(V_VIS + V_FP),
    .SYNC_END  (V_VIS + V_FP + V_SYNC - 1),
    .VIS       (V_VIS)
  ) u_v (
    .clk   (frame_Clk),
    .rst   (Reset),
    .en    (h_wrap),
    .count (DrawY),
    .wrap  (v_wrap),
    .sync_n(VS),
    .vis   (v_vis)
  );

  always_ff @(posedge frame_Clk or posedge Reset) begin
    if (Reset) begin
      blank_q <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      blank_q <= h_vis & v_vis;
      fs_q    <= h_wrap & v_wrap;
    end
  end

  assign blank_n    = blank_q;
  assign frameStart = fs_q;
  assign VState     = vdecode(DrawY, VV, VFE, VSE);

endmodule
